wm_phase_timer: RTL

- Timing controller for the washing machine FSM.
- Watches the FSM status outputs to detect the active wash, rinse and spin phases.
- Runs a prescaled down-counter per phase, with duration set by a program selector latched at start.
- Drives the FSM's timeout and spin_timeout inputs, replacing the hand-driven timing inputs used at bench level.

---
 rtl/wm_pkg.sv | 25 ++
 rtl/wm_tick_prescaler.sv | 37 +++
 rtl/wm_phase_timer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/wm_pkg.sv
// Shared encodings and default durations for the washing-machine phase timer.
package wm_pkg;

    // Phase encoding, also presented on the phase output
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_WASH  = 2'd1,
        PH_RINSE = 2'd2,
        PH_SPIN  = 2'd3
    } phase_e;

    // Program selector encoding; duration multiplier is prog+1
    localparam logic [1:0] PROG_QUICK  = 2'd0;
    localparam logic [1:0] PROG_NORMAL = 2'd1;
    localparam logic [1:0] PROG_HEAVY  = 2'd2;
    localparam logic [1:0] PROG_EXTRA  = 2'd3;

    // Default timing (ticks for the quick program, clk cycles per tick)
    localparam int DEF_TICK_DIV   = 10;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_WASH_BASE  = 4;
    localparam int DEF_RINSE_BASE = 3;
    localparam int DEF_SPIN_BASE  = 2;

endpackage

// File: rtl/wm_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
module wm_tick_prescaler #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    // Tick only fires on an enabled cycle, so a held count never ticks
    assign tick = en & (cnt_q == LAST);

    // Next count: clear on phase load, otherwise wrap 0..TICK_DIV-1 while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end

    // Count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wm_phase_timer.sv
// Phase timer: tracks wash/rinse/spin from FSM status and raises timeout /
// spin_timeout after a program-scaled number of prescaled ticks.
module wm_phase_timer
    import wm_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int WASH_BASE  = DEF_WASH_BASE,
    parameter int RINSE_BASE = DEF_RINSE_BASE,
    parameter int SPIN_BASE  = DEF_SPIN_BASE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       prog_sel,
    input  logic             pause,
    input  logic             motor_on,
    input  logic             drain_on,
    input  logic             soapWash,
    input  logic             waterWash,
    input  logic             done,
    output logic             timeout,
    output logic             spin_timeout,
    output logic             busy,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] remaining
);

    // Load arithmetic is carried three bits wider than the counter so that
    // base*(prog+1) cannot wrap before saturation.
    localparam int LW = CNT_W + 3;
    localparam logic [LW-1:0] SAT = {3'b000, {CNT_W{1'b1}}};

    phase_e           state_q, state_d;
    logic [1:0]       prog_q, prog_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             timeout_q, timeout_d;
    logic             spin_q, spin_d;
    logic             busy_q, busy_d;

    logic             wash_c, rinse_c, spin_c;
    phase_e           cond_ph;
    logic [1:0]       prog_eff;
    logic [LW-1:0]    base, mult, prod;
    logic [CNT_W-1:0] load_val;
    logic             load_en;
    logic             tick;

    // Phase conditions are mutually exclusive by construction
    assign wash_c  = motor_on & soapWash;
    assign rinse_c = motor_on & waterWash & ~soapWash;
    assign spin_c  = motor_on & drain_on & ~soapWash & ~waterWash;

    // Prioritised phase request from the current FSM status
    always_comb begin
        cond_ph = PH_IDLE;
        if (wash_c)
            cond_ph = PH_WASH;
        else if (rinse_c)
            cond_ph = PH_RINSE;
        else if (spin_c)
            cond_ph = PH_SPIN;
    end

    // Load value: base*(prog+1), saturated to the counter range, never zero.
    // A start arriving on the load edge already selects the new program.
    always_comb begin
        prog_eff = start ? prog_sel : prog_q;
        case (cond_ph)
            PH_WASH:  base = LW'(WASH_BASE);
            PH_RINSE: base = LW'(RINSE_BASE);
            default:  base = LW'(SPIN_BASE);
        endcase
        mult = LW'(prog_eff) + LW'(1);
        prod = base * mult;
        if (prod > SAT)
            load_val = SAT[CNT_W-1:0];
        else if (prod == '0)
            load_val = CNT_W'(1);
        else
            load_val = prod[CNT_W-1:0];
    end

    // Next-state logic for phase tracking, countdown and expiry flags
    always_comb begin
        state_d   = state_q;
        prog_d    = prog_q;
        rem_d     = rem_q;
        timeout_d = timeout_q;
        spin_d    = spin_q;
        load_en   = 1'b0;

        if (state_q == PH_IDLE && start)
            prog_d = prog_sel;

        if (done) begin
            state_d   = PH_IDLE;
            rem_d     = '0;
            timeout_d = 1'b0;
            spin_d    = 1'b0;
        end else if (state_q == PH_IDLE) begin
            if (cond_ph != PH_IDLE) begin
                state_d   = cond_ph;
                rem_d     = load_val;
                timeout_d = 1'b0;
                spin_d    = 1'b0;
                load_en   = 1'b1;
            end
        end else if (cond_ph != state_q) begin
            // Phase left (expired or aborted): always pass through IDLE
            state_d   = PH_IDLE;
            rem_d     = '0;
            timeout_d = 1'b0;
            spin_d    = 1'b0;
        end else if (tick && rem_q != '0) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
                if (state_q == PH_SPIN)
                    spin_d = 1'b1;
                else
                    timeout_d = 1'b1;
            end
        end

        busy_d = (state_d != PH_IDLE);
    end

    // Phase FSM with registered outputs; async reset drops timeouts at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= PH_IDLE;
            prog_q    <= PROG_NORMAL;
            rem_q     <= '0;
            timeout_q <= 1'b0;
            spin_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prog_q    <= prog_d;
            rem_q     <= rem_d;
            timeout_q <= timeout_d;
            spin_q    <= spin_d;
            busy_q    <= busy_d;
        end
    end

    wm_tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (~pause),
        .clr    (load_en),
        .tick   (tick)
    );

    assign timeout      = timeout_q;
    assign spin_timeout = spin_q;
    assign busy         = busy_q;
    assign phase        = state_q;
    assign remaining    = rem_q;

endmodule
